// File: rtl/iterative_shifter.sv
// Multi-cycle shift unit: SLL, SRL, SRA and ROTR, one bit position per clock.
// A request is accepted from IDLE or DONE; result is published only on completion.
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_ROTR = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  if ((2 ** SHAMT_W) != WIDTH) begin : g_param_check
    $error("iterative_shifter: 2**SHAMT_W must equal WIDTH");
  end

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_work;
  logic [1:0]         r_op;
  logic [SHAMT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_step;
  logic               w_accept;

  // Single-position shift of the working register for the latched opcode.
  always_comb begin
    w_step = r_work;
    case (r_op)
      OP_SLL:  w_step = {r_work[WIDTH-2:0], 1'b0};
      OP_SRL:  w_step = {1'b0, r_work[WIDTH-1:1]};
      OP_SRA:  w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      OP_ROTR: w_step = {r_work[0], r_work[WIDTH-1:1]};
      default: w_step = r_work;
    endcase
  end

  assign w_accept = start && (r_state != ST_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_work   <= '0;
      r_op     <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_work  <= operand;
            r_op    <= op;
            r_count <= shamt;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (r_count != '0) begin
            r_work  <= w_step;
            r_count <= r_count - 1'b1;
          end else begin
            r_result <= r_work;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
